// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sample master: FSM state encoding,
// word widths, bit-counter sizing and the SPI mode-0 clock constants.
package spi_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CMD_W     = 8;
  localparam int unsigned BIT_CNT_W = 5;

  // SPI mode 0: clock idles low, data sampled on the rising edge
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    DATA,
    HOLD,
    OUT
  } state_t;

  // Bit counter runs across command and data without clearing in between,
  // so its terminal values are cumulative: 7 ends the command, 23 the frame.
  localparam logic [BIT_CNT_W-1:0] LAST_CMD_BIT = BIT_CNT_W'(CMD_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(CMD_W + DATA_W - 1);

  // States in which the half-period counter runs (chip select asserted)
  function automatic logic frame_active(input state_t s);
    return (s == SETUP) || (s == CMD) || (s == DATA) || (s == HOLD);
  endfunction

  // States in which SCK is allowed to toggle
  function automatic logic sck_active(input state_t s);
    return (s == CMD) || (s == DATA);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer. Counts CLK_DIV clk cycles while enabled and
// raises a one-cycle tick in the last cycle of each half-period. When
// toggling is allowed, the tick is qualified into sck_rise / sck_fall
// strobes according to the current registered SCK level.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  input  logic sck_level,
  output logic tick,
  output logic sck_rise,
  output logic sck_fall
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // Half-period counter: held at zero when disabled, wraps after CLK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Strobes announce the edge that the FSM will register on the next clk
  always_comb begin
    tick     = en && (cnt == CNT_LAST);
    sck_rise = tick && toggle_en && (sck_level == CPOL);
    sck_fall = tick && toggle_en && (sck_level != CPOL);
  end

endmodule

// File: rtl/spi_sample_master.sv
// SPI mode-0 master that reads one 16-bit sample per frame: it shifts
// CMD_BYTE out on MOSI, then shifts 16 bits in from MISO (MSB first) and
// presents them through a valid/ready output buffer.
// Optional feature: define SPI_AUTO_SAMPLE_EN to add an internal period
// counter that requests a frame every SAMPLE_PERIOD clk cycles.
module spi_sample_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter logic [7:0]  CMD_BYTE      = 8'h80,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_clk_div
    $error("spi_sample_master: CLK_DIV must be in 1..255");
  end

  if (SAMPLE_PERIOD < 1) begin : g_bad_period
    $error("spi_sample_master: SAMPLE_PERIOD must be at least 1");
  end

  if ((CPOL != 1'b0) || (CPHA != 1'b0)) begin : g_bad_mode
    $error("spi_sample_master: only SPI mode 0 is implemented");
  end

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [CMD_W-1:0]     cmd_sr;
  logic [DATA_W-1:0]    data_sr;
  logic                 miso_meta;
  logic                 miso_sync;
  logic                 start_req;
  logic                 tick;
  logic                 sck_rise;
  logic                 sck_fall;

`ifdef SPI_AUTO_SAMPLE_EN
  localparam logic [31:0] PERIOD_LAST = 32'(SAMPLE_PERIOD - 1);

  logic [31:0] period_cnt;

  // Free-running sample period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 32'd1;
    end
  end

  // Auto pulse fires when the counter is at zero, so the first one lands on
  // the first edge after reset; it obeys the same ignore rules as the port.
  always_comb begin
    start_req = start | (period_cnt == '0);
  end
`else
  // Frames are requested only through the start port
  always_comb begin
    start_req = start;
  end
`endif

  // Two-flop synchronizer on the asynchronous MISO input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= spi_miso;
      miso_sync <= miso_meta;
    end
  end

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (frame_active(state)),
    .toggle_en(sck_active(state)),
    .sck_level(spi_sck),
    .tick     (tick),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Frame sequencer with registered SPI pins and output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      cmd_sr       <= '0;
      data_sr      <= '0;
      busy         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      spi_sck      <= CPOL;
      spi_cs_n     <= 1'b1;
      spi_mosi     <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // sample_valid is the pre-handshake value, so a start coinciding
          // with the consumer's accept is dropped rather than queued
          if (start_req && !sample_valid) begin
            state    <= SETUP;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_mosi <= CMD_BYTE[CMD_W-1];
            cmd_sr   <= CMD_BYTE;
            bit_cnt  <= '0;
            data_sr  <= '0;
          end
        end

        SETUP: begin
          if (tick) begin
            state <= CMD;
          end
        end

        CMD: begin
          if (sck_rise) begin
            spi_sck <= ~CPOL;
          end else if (sck_fall) begin
            spi_sck <= CPOL;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_CMD_BIT) begin
              state    <= DATA;
              spi_mosi <= 1'b0;
            end else begin
              spi_mosi <= cmd_sr[CMD_W-2];
              cmd_sr   <= {cmd_sr[CMD_W-2:0], 1'b0};
            end
          end
        end

        DATA: begin
          if (sck_rise) begin
            spi_sck <= ~CPOL;
            data_sr <= {data_sr[DATA_W-2:0], miso_sync};
          end else if (sck_fall) begin
            spi_sck <= CPOL;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (tick) begin
            state        <= OUT;
            spi_cs_n     <= 1'b1;
            busy         <= 1'b0;
            sample_valid <= 1'b1;
            sample_data  <= data_sr;
          end
        end

        OUT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_master.sv
// Directed bench for spi_sample_master with CLK_DIV=2. A small sensor
// model drives MISO and records MOSI; negedge monitors keep running totals
// of chip-select-low cycles, SCK rises and sample_valid rises.
// Build with SPI_AUTO_SAMPLE_EN defined to run the auto-trigger scenario.
module tb_spi_sample_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sens_word  = 16'h0000;
  int          sens_rises = 0;
  logic [7:0]  cmd_seen   = 8'h00;

  int   cyc            = 0;
  int   cs_low_total   = 0;
  int   sck_rise_total = 0;
  int   valid_rises    = 0;
  int   last_fall      = 0;
  int   prev_fall      = 0;
  logic valid_q        = 1'b0;
  logic cs_q           = 1'b1;

  int base_cs;
  int base_sck;
  int base_valid;

  always #5 clk = ~clk;

  spi_sample_master #(
    .CLK_DIV      (2),
    .CMD_BYTE     (8'h80),
    .SAMPLE_PERIOD(200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  // Sensor: counts SCK rises since CS fell, logs the first 8 MOSI bits and
  // moves to the next data bit right after each data-phase rise.
  always @(posedge spi_sck or negedge spi_cs_n) begin
    if (spi_sck) begin
      if (sens_rises < 8) cmd_seen = {cmd_seen[6:0], spi_mosi};
      sens_rises     = sens_rises + 1;
      sck_rise_total = sck_rise_total + 1;
    end else begin
      sens_rises = 0;
    end
  end

  always_comb begin
    spi_miso = 1'b0;
    if (!spi_cs_n) begin
      if (sens_rises < 8) spi_miso = sens_word[15];
      else if (sens_rises < 24) spi_miso = sens_word[23 - sens_rises];
    end
  end

  // Running totals sampled away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!spi_cs_n) cs_low_total = cs_low_total + 1;
    if (sample_valid && !valid_q) valid_rises = valid_rises + 1;
    if (!spi_cs_n && cs_q) begin
      prev_fall = last_fall;
      last_fall = cyc;
    end
    valid_q = sample_valid;
    cs_q    = spi_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n",  32'(spi_cs_n),     32'h1);
    check("rst_sck",   32'(spi_sck),      32'h0);
    check("rst_mosi",  32'(spi_mosi),     32'h0);
    check("rst_busy",  32'(busy),         32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_data",  32'(sample_data),  32'h0);

`ifdef SPI_AUTO_SAMPLE_EN
    // Auto trigger: ready tied high, frames every 200 cycles
    sens_word    = 16'h5A3C;
    sample_ready = 1'b1;
    base_valid   = valid_rises;
    rst          = 1'b0;
    repeat (600) @(negedge clk);
    check("auto_words",   32'(valid_rises - base_valid), 32'd3);
    check("auto_spacing", 32'(last_fall - prev_fall),    32'd200);
    check("auto_data",    32'(sample_data),              32'h5A3C);
`else
    rst = 1'b0;
    @(negedge clk);

    // Normal frame
    sens_word = 16'hA5C3;
    base_cs   = cs_low_total;
    base_sck  = sck_rise_total;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("n_cs_c1",    32'(spi_cs_n), 32'h0);
    check("n_busy_c1",  32'(busy),     32'h1);
    check("n_mosi_c1",  32'(spi_mosi), 32'h1);
    repeat (99) @(negedge clk);
    check("n_cs_c100",    32'(spi_cs_n),     32'h0);
    check("n_valid_c100", 32'(sample_valid), 32'h0);
    @(negedge clk);
    check("n_cs_c101",    32'(spi_cs_n),                  32'h1);
    check("n_valid_c101", 32'(sample_valid),              32'h1);
    check("n_busy_c101",  32'(busy),                      32'h0);
    check("n_data",       32'(sample_data),               32'hA5C3);
    check("n_cmd_mosi",   32'(cmd_seen),                  32'h80);
    check("n_cs_low",     32'(cs_low_total - base_cs),    32'd100);
    check("n_sck_rises",  32'(sck_rise_total - base_sck), 32'd24);

    // Backpressure: two starts while the buffer is full are both dropped
    sens_word = 16'hFFFF;
    base_cs   = cs_low_total;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (120) @(negedge clk);
    check("bp_no_frame", 32'(cs_low_total - base_cs), 32'd0);
    check("bp_busy",     32'(busy),                   32'h0);
    check("bp_valid",    32'(sample_valid),           32'h1);
    check("bp_data",     32'(sample_data),            32'hA5C3);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("bp_valid_clr", 32'(sample_valid), 32'h0);
    check("bp_data_keep", 32'(sample_data),  32'hA5C3);

    // Busy guard: start in cycle 40 of a frame is ignored
    sens_word = 16'h3C5A;
    base_cs   = cs_low_total;
    base_sck  = sck_rise_total;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("bg_busy_c40", 32'(busy), 32'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("bg_valid",     32'(sample_valid),              32'h1);
    check("bg_data",      32'(sample_data),               32'h3C5A);
    check("bg_sck_rises", 32'(sck_rise_total - base_sck), 32'd24);
    repeat (60) @(negedge clk);
    check("bg_one_frame", 32'(cs_low_total - base_cs),    32'd100);

    // Handshake and start in the same cycle
    base_cs      = cs_low_total;
    sample_ready = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    start        = 1'b0;
    check("hs_valid_clr", 32'(sample_valid), 32'h0);
    check("hs_busy",      32'(busy),         32'h0);
    repeat (20) @(negedge clk);
    check("hs_no_frame",  32'(cs_low_total - base_cs), 32'd0);

    // Reset in cycle 30 while SCK is high
    sens_word = 16'hBEEF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("rm_sck_hi_c30", 32'(spi_sck), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rm_cs_n",  32'(spi_cs_n),     32'h1);
    check("rm_sck",   32'(spi_sck),      32'h0);
    check("rm_valid", 32'(sample_valid), 32'h0);
    check("rm_busy",  32'(busy),         32'h0);
    @(negedge clk);
    check("rm_data_clr", 32'(sample_data), 32'h0);
    sens_word = 16'h1234;
    rst       = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rm_first_start", 32'(spi_cs_n), 32'h0);
    repeat (100) @(negedge clk);
    check("rm_valid_c101", 32'(sample_valid), 32'h1);
    check("rm_data",       32'(sample_data),  32'h1234);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("rm_valid_clr", 32'(sample_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
